column_drain: RTL and testbench

Output stage below the last vertical_node of a column in the accumulation array. It samples the column's final partial sum and carry on a capture strobe, optionally saturates on overflow, and registers the result. It then buffers results in a small FIFO and hands them downstream over a valid/ready handshake. It decouples the array's fixed-rate column output from a back-pressured result sink.

---
 rtl/column_drain_pkg.sv | 24 ++
 rtl/column_drain_fifo.sv | 84 ++++++++
 rtl/column_drain.sv | 82 ++++++++
 tb/tb_column_drain.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_drain_pkg.sv
// column_drain shared definitions.
// Width derivation, saturation constants and pointer width.
package column_drain_pkg;

  localparam int F_WIDTH_DEF = 8;
  localparam int I_WIDTH_DEF = 8;

  function automatic int data_w(int i_w, int f_w);
    return i_w + f_w;
  endfunction

  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [63:0] sat_max(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/column_drain_fifo.sv
// Circular FIFO with wrap-bit pointers, registered count and drop pulse.
// push_i/data_i in, pop_i out, data_o/valid_o head, count_o, drop_o.
module column_drain_fifo
  import column_drain_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int PW   = ptr_w(DEPTH),
  localparam int AW   = PW - 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic [PW-1:0] count_o,
  output logic          drop_o
);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the slot a same-cycle push needs.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    drop_d = 1'b0;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d   = wr_q + PW'(do_push);
      rd_d   = rd_q + PW'(do_pop);
      cnt_d  = cnt_q + PW'(do_push) - PW'(do_pop);
      drop_d = push_i & ~do_push;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign valid_o = ~empty;
  assign count_o = cnt_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/column_drain.sv
// Column output stage: capture, optional saturation, FIFO, valid/ready.
// node_data_i/node_c_i on capture_i -> out_data_o/out_valid_o/out_ready_i.
module column_drain
  import column_drain_pkg::*;
#(
  parameter int F_WIDTH = F_WIDTH_DEF,
  parameter int I_WIDTH = I_WIDTH_DEF,
  parameter int DEPTH   = 4,
  localparam int W      = data_w(I_WIDTH, F_WIDTH),
  localparam int CW     = ptr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic [W-1:0]  node_data_i,
  input  logic          node_c_i,
  input  logic          capture_i,
  input  logic          sat_en_i,
  output logic [W-1:0]  out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [CW-1:0] count_o,
  output logic          sat_o,
  output logic          drop_o
);

  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

  logic         s_v_q, s_v_d;
  logic [W-1:0] s_data_q, s_data_d;
  logic         sat_q, sat_d;
  logic         ovf;

  assign ovf = capture_i & node_c_i & sat_en_i;

  // A carry out with MSB set means the true sum was positive.
  always_comb begin
    s_v_d    = capture_i;
    s_data_d = node_data_i;
    sat_d    = sat_q;
    if (ovf) begin
      s_data_d = node_data_i[W-1] ? SAT_MAX : SAT_MIN;
      sat_d    = 1'b1;
    end
    if (clr_i) begin
      s_v_d = 1'b0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_v_q    <= 1'b0;
      s_data_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      s_v_q    <= s_v_d;
      s_data_q <= s_data_d;
      sat_q    <= sat_d;
    end
  end

  column_drain_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (clr_i),
    .push_i  (s_v_q),
    .data_i  (s_data_q),
    .pop_i   (out_ready_i),
    .data_o  (out_data_o),
    .valid_o (out_valid_o),
    .count_o (count_o),
    .drop_o  (drop_o)
  );

  assign sat_o = sat_q;

endmodule

// File: tb/tb_column_drain.sv
// Self-checking bench for column_drain with a queue-based reference.
// Directed vectors plus a per-cycle model compare.
module tb_column_drain;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n_i;
  logic        clr_i;
  logic [15:0] node_data_i;
  logic        node_c_i;
  logic        capture_i;
  logic        sat_en_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  count_o;
  logic        sat_o;
  logic        drop_o;

  int checks;
  int failures;

  column_drain #(
    .F_WIDTH (8),
    .I_WIDTH (8),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .clr_i       (clr_i),
    .node_data_i (node_data_i),
    .node_c_i    (node_c_i),
    .capture_i   (capture_i),
    .sat_en_i    (sat_en_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .count_o     (count_o),
    .sat_o       (sat_o),
    .drop_o      (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: one pending stage slot and a bounded queue.
  logic [15:0] mq[$];
  logic        pend_v;
  logic [15:0] pend_d;
  logic        m_sat;
  logic        m_drop;
  logic        last_valid;
  logic [15:0] last_data;
  logic        hold_exp;

  initial begin
    pend_v     = 1'b0;
    pend_d     = '0;
    m_sat      = 1'b0;
    m_drop     = 1'b0;
    last_valid = 1'b0;
    last_data  = '0;
  end

  always @(posedge clk) begin
    hold_exp = last_valid && !out_ready_i && !clr_i && rst_n_i;
    if (!rst_n_i || clr_i) begin
      mq.delete();
      pend_v = 1'b0;
      m_sat  = 1'b0;
      m_drop = 1'b0;
    end else begin
      logic pop;
      pop    = (mq.size() > 0) && out_ready_i;
      m_drop = pend_v && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (pend_v && !m_drop) mq.push_back(pend_d);
      pend_v = capture_i;
      pend_d = node_data_i;
      if (capture_i && node_c_i && sat_en_i) begin
        pend_d = node_data_i[15] ? 16'h7FFF : 16'h8000;
        m_sat  = 1'b1;
      end
    end
    #1;
    chk("valid", 32'(out_valid_o), 32'(mq.size() > 0));
    chk("count", 32'(count_o), 32'(mq.size()));
    chk("sat", 32'(sat_o), 32'(m_sat));
    chk("drop", 32'(drop_o), 32'(m_drop));
    if (mq.size() > 0) chk("data", 32'(out_data_o), 32'(mq[0]));
    if (hold_exp && rst_n_i) chk("hold", 32'(out_data_o), 32'(last_data));
    last_valid = out_valid_o;
    last_data  = out_data_o;
  end

  task automatic cyc(input logic cap, input logic [15:0] d,
                     input logic c);
    capture_i   = cap;
    node_data_i = d;
    node_c_i    = c;
    @(negedge clk);
  endtask

  logic dropv [8];

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n_i     = 1'b0;
    clr_i       = 1'b0;
    node_data_i = '0;
    node_c_i    = 1'b0;
    capture_i   = 1'b0;
    sat_en_i    = 1'b0;
    out_ready_i = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_sat", 32'(sat_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;

    // Single capture latency
    cyc(1, 16'h0123, 0);
    chk("lat_v0", 32'(out_valid_o), 32'd0);
    cyc(0, 0, 0);
    chk("lat_v1", 32'(out_valid_o), 32'd1);
    chk("lat_d", 32'(out_data_o), 32'h0123);
    chk("lat_cnt", 32'(count_o), 32'd1);
    out_ready_i = 1;
    cyc(0, 0, 0);
    out_ready_i = 0;
    chk("pop_cnt", 32'(count_o), 32'd0);

    // Saturation on
    sat_en_i = 1;
    cyc(1, 16'h8001, 1);
    cyc(1, 16'h7FFE, 1);
    cyc(0, 0, 0);
    chk("sat_d0", 32'(out_data_o), 32'h7FFF);
    chk("sat_cnt", 32'(count_o), 32'd2);
    chk("sat_flag", 32'(sat_o), 32'd1);
    out_ready_i = 1;
    cyc(0, 0, 0);
    chk("sat_d1", 32'(out_data_o), 32'h8000);
    cyc(0, 0, 0);
    out_ready_i = 0;
    chk("sat_held", 32'(sat_o), 32'd1);
    clr_i = 1;
    cyc(0, 0, 0);
    clr_i = 0;
    chk("sat_clr", 32'(sat_o), 32'd0);

    // Saturation off
    sat_en_i = 0;
    cyc(1, 16'h8001, 1);
    cyc(1, 16'h7FFE, 1);
    cyc(0, 0, 0);
    chk("raw_d0", 32'(out_data_o), 32'h8001);
    chk("raw_sat", 32'(sat_o), 32'd0);
    out_ready_i = 1;
    cyc(0, 0, 0);
    chk("raw_d1", 32'(out_data_o), 32'h7FFE);
    cyc(0, 0, 0);
    out_ready_i = 0;

    // Overfill with ready low
    for (int i = 0; i < 6; i++) begin
      cyc(1, 16'h0010 + 16'(i), 0);
      dropv[i] = drop_o;
    end
    cyc(0, 0, 0);
    dropv[6] = drop_o;
    cyc(0, 0, 0);
    dropv[7] = drop_o;
    chk("full_cnt", 32'(count_o), 32'd4);
    chk("drop4", 32'(dropv[4]), 32'd0);
    chk("drop5", 32'(dropv[5]), 32'd1);
    chk("drop6", 32'(dropv[6]), 32'd1);
    chk("drop7", 32'(dropv[7]), 32'd0);
    out_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain", 32'(out_data_o), 32'h10 + 32'(i));
      cyc(0, 0, 0);
    end
    chk("drain_cnt", 32'(count_o), 32'd0);
    out_ready_i = 0;

    // Full with simultaneous push and pop
    for (int i = 0; i < 5; i++) cyc(1, 16'h0040 + 16'(i), 0);
    chk("pp_fill", 32'(count_o), 32'd4);
    out_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 16'h0050 + 16'(i), 0);
      chk("pp_cnt", 32'(count_o), 32'd4);
      chk("pp_drop", 32'(drop_o), 32'd0);
    end
    repeat (6) cyc(0, 0, 0);
    chk("pp_empty", 32'(count_o), 32'd0);

    // Random back-pressure
    for (int i = 0; i < 60; i++) begin
      out_ready_i = 1'($urandom_range(0, 1));
      cyc(1, 16'h0100 + 16'(i), 0);
    end
    out_ready_i = 1;
    repeat (8) cyc(0, 0, 0);
    out_ready_i = 0;

    // Async reset mid-burst
    sat_en_i = 1;
    cyc(1, 16'h8001, 1);
    cyc(1, 16'h0200, 0);
    cyc(1, 16'h0201, 0);
    #2;
    rst_n_i = 0;
    #1;
    chk("ar_valid", 32'(out_valid_o), 32'd0);
    chk("ar_count", 32'(count_o), 32'd0);
    chk("ar_sat", 32'(sat_o), 32'd0);
    @(negedge clk);
    rst_n_i = 1;
    cyc(0, 0, 0);
    chk("ar_after", 32'(count_o), 32'd0);

    // Clear with concurrent push
    cyc(1, 16'h0300, 0);
    cyc(1, 16'h0301, 1);
    cyc(1, 16'h0302, 0);
    chk("cl_pre", 32'(count_o), 32'd2);
    chk("cl_psat", 32'(sat_o), 32'd1);
    clr_i = 1;
    cyc(1, 16'h0303, 0);
    clr_i = 0;
    chk("cl_valid", 32'(out_valid_o), 32'd0);
    chk("cl_count", 32'(count_o), 32'd0);
    chk("cl_sat", 32'(sat_o), 32'd0);
    chk("cl_drop", 32'(drop_o), 32'd0);
    cyc(0, 0, 0);
    chk("cl_next", 32'(count_o), 32'd0);
    repeat (2) cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
